fifo_ctrl_64_32: RTL

FIFO_CTRL_64_32 -- requirements
Module: fifo_ctrl_64_32

---
 rtl/fifo_ctrl_64_32.sv | 103 ++++++++++
 1 files changed

// File: rtl/fifo_ctrl_64_32.sv
// Synchronous FIFO controller for an external 64x32 DFF register file.
// The register file has a one-cycle registered read port, so popped data arrives one cycle after the pop.
module fifo_ctrl_64_32 #(
  parameter int ADDR     = 6,
  parameter int WORDS    = 64,
  parameter int W_SIZE   = 32,
  parameter int AFULL_TH = 56
) (
  input  logic              fifo_clk,
  input  logic              fifo_rst_n,
  input  logic              fifo_clr,
  input  logic              fifo_push,
  input  logic [W_SIZE-1:0] fifo_wdata,
  input  logic              fifo_pop,
  output logic [W_SIZE-1:0] fifo_rdata,
  output logic              fifo_rvalid,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_afull,
  output logic [ADDR:0]     fifo_count,
  output logic              fifo_ovf,
  output logic              fifo_udf,
  output logic              mem_wen,
  output logic [ADDR-1:0]   mem_waddr,
  output logic [W_SIZE-1:0] mem_wdata,
  output logic [ADDR-1:0]   mem_raddr,
  input  logic [W_SIZE-1:0] mem_rdata
);

  localparam logic [ADDR-1:0] LAST_PTR = ADDR'(WORDS - 1);
  localparam logic [ADDR:0]   FULL_CNT = (ADDR + 1)'(WORDS);
  localparam logic [ADDR:0]   AFULL_CNT = (ADDR + 1)'(AFULL_TH);

  logic [ADDR-1:0] wr_ptr;
  logic [ADDR-1:0] rd_ptr;
  logic [ADDR:0]   count;
  logic [ADDR:0]   count_nxt;
  logic            rvalid_p1;
  logic            ovf;
  logic            udf;
  logic            push_ok;
  logic            pop_ok;

  function automatic logic [ADDR-1:0] ptr_inc(input logic [ADDR-1:0] p);
    ptr_inc = (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Flags decode the registered count only.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_afull = (count >= AFULL_CNT);
  assign fifo_count = count;
  assign fifo_ovf   = ovf;
  assign fifo_udf   = udf;

  // Gating with reset keeps the register file write-disabled while reset is held.
  assign pop_ok  = fifo_rst_n & fifo_pop & ~fifo_clr & ~fifo_empty;
  assign push_ok = fifo_rst_n & fifo_push & ~fifo_clr & (~fifo_full | pop_ok);

  assign mem_wen   = push_ok;
  assign mem_waddr = wr_ptr;
  assign mem_wdata = fifo_wdata;
  assign mem_raddr = rd_ptr;

  assign fifo_rdata  = mem_rdata;
  assign fifo_rvalid = rvalid_p1;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Stage p1: pointer/count update; rvalid_p1 lines up with the register file read latency.
  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rvalid_p1 <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else if (fifo_clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rvalid_p1 <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      count     <= count_nxt;
      rvalid_p1 <= pop_ok;
      if (fifo_push && !push_ok)   ovf <= 1'b1;
      if (fifo_pop  && fifo_empty) udf <= 1'b1;
    end
  end

endmodule
